// File: rtl/alu_pkg.sv
// Opcode encodings, scheduler state type and opcode helpers shared by the
// ALU and the round-robin scheduler around it.
package alu_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_NOT = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } alu_sched_state_t;

    // 110 and 111 are unassigned encodings; the ALU returns zero for them.
    function automatic logic is_illegal_op(input logic [2:0] op);
        return op[2] & op[1];
    endfunction

endpackage

// File: rtl/alu_8bit.sv
// 8-bit ALU with a registered output stage: result, carry/borrow and zero
// flag are latched on every rising edge from the current operands.
module alu_8bit (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic [2:0] op,
    output logic [7:0] result,
    output logic       carry,
    output logic       zero
);
    import alu_pkg::*;

    logic [8:0] wide_next;
    logic [7:0] result_reg;
    logic       carry_reg;
    logic       zero_reg;

    // Bit 8 carries the ADD carry-out or the SUB borrow; logic ops leave it 0.
    always_comb begin
        wide_next = 9'd0;
        case (op)
            OP_ADD:  wide_next = {1'b0, a} + {1'b0, b};
            OP_SUB:  wide_next = {1'b0, a} - {1'b0, b};
            OP_AND:  wide_next = {1'b0, a & b};
            OP_OR:   wide_next = {1'b0, a | b};
            OP_XOR:  wide_next = {1'b0, a ^ b};
            OP_NOT:  wide_next = {1'b0, ~a};
            default: wide_next = 9'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_reg <= 8'h00;
            carry_reg  <= 1'b0;
            zero_reg   <= 1'b1;
        end else begin
            result_reg <= wide_next[7:0];
            carry_reg  <= wide_next[8];
            zero_reg   <= (wide_next[7:0] == 8'h00);
        end
    end

    assign result = result_reg;
    assign carry  = carry_reg;
    assign zero   = zero_reg;

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr,
// wrapping modulo NUM_REQ.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_idx,
    output logic               grant_valid
);

    logic [ID_W:0]   sum_w;
    logic [ID_W-1:0] idx_v;

    // Scan from the farthest offset down so the closest valid request wins.
    always_comb begin
        grant_idx   = '0;
        grant_valid = 1'b0;
        sum_w       = '0;
        idx_v       = '0;
        for (int off = NUM_REQ - 1; off >= 0; off--) begin
            sum_w = {1'b0, ptr} + (ID_W + 1)'(off);
            if (sum_w >= (ID_W + 1)'(NUM_REQ)) begin
                sum_w = sum_w - (ID_W + 1)'(NUM_REQ);
            end
            idx_v = sum_w[ID_W-1:0];
            if (req[idx_v]) begin
                grant_idx   = idx_v;
                grant_valid = 1'b1;
            end
        end
        grant = grant_valid ? (NUM_REQ'(1) << grant_idx) : '0;
    end

endmodule

// File: rtl/alu_rr_scheduler.sv
// Shares one registered ALU among NUM_REQ requesters: round-robin grant in
// IDLE, one EXEC cycle for the ALU to latch, then a held RESP until accepted.
module alu_rr_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [NUM_REQ*8-1:0] req_a,
    input  logic [NUM_REQ*8-1:0] req_b,
    input  logic [NUM_REQ*3-1:0] req_op,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [ID_W-1:0]      rsp_id,
    output logic [7:0]           rsp_result,
    output logic                 rsp_carry,
    output logic                 rsp_zero,
    output logic                 rsp_illegal,
    output logic                 busy
);
    import alu_pkg::*;

    logic [7:0] a_arr  [NUM_REQ];
    logic [7:0] b_arr  [NUM_REQ];
    logic [2:0] op_arr [NUM_REQ];

    genvar gi;
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign a_arr[gi]  = req_a[8*gi +: 8];
        assign b_arr[gi]  = req_b[8*gi +: 8];
        assign op_arr[gi] = req_op[3*gi +: 3];
    end

    alu_sched_state_t  state_reg;
    logic [ID_W-1:0]   ptr_reg;
    logic [ID_W-1:0]   ptr_next;
    logic [7:0]        a_reg;
    logic [7:0]        b_reg;
    logic [2:0]        op_reg;
    logic [ID_W-1:0]   id_reg;
    logic              illegal_reg;
    logic              rsp_valid_reg;
    logic              busy_reg;

    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_idx;
    logic               grant_valid;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arbiter (
        .req         (req_valid),
        .ptr         (ptr_reg),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    assign ptr_next  = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
    assign req_ready = (state_reg == IDLE && !rst) ? grant : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            ptr_reg       <= '0;
            a_reg         <= 8'h00;
            b_reg         <= 8'h00;
            op_reg        <= OP_ADD;
            id_reg        <= '0;
            illegal_reg   <= 1'b0;
            rsp_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (grant_valid) begin
                        a_reg       <= a_arr[grant_idx];
                        b_reg       <= b_arr[grant_idx];
                        op_reg      <= op_arr[grant_idx];
                        id_reg      <= grant_idx;
                        illegal_reg <= is_illegal_op(op_arr[grant_idx]);
                        ptr_reg     <= ptr_next;
                        busy_reg    <= 1'b1;
                        state_reg   <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_valid_reg <= 1'b1;
                    state_reg     <= RESP;
                end
                RESP: begin
                    // Operands stay put, so the ALU keeps presenting the same result.
                    if (rsp_ready) begin
                        rsp_valid_reg <= 1'b0;
                        busy_reg      <= 1'b0;
                        state_reg     <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    logic rst_n;
    assign rst_n = ~rst;

    alu_8bit u_alu (
        .clk    (clk),
        .rst_n  (rst_n),
        .a      (a_reg),
        .b      (b_reg),
        .op     (op_reg),
        .result (rsp_result),
        .carry  (rsp_carry),
        .zero   (rsp_zero)
    );

    assign rsp_valid   = rsp_valid_reg;
    assign rsp_id      = id_reg;
    assign rsp_illegal = illegal_reg;
    assign busy        = busy_reg;

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Scoreboard bench for alu_rr_scheduler: directed scenarios plus random
// traffic, checked against a pointer/queue reference model.
module tb_alu_rr_scheduler;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ-1:0]   req_ready;
    logic [NUM_REQ*8-1:0] req_a;
    logic [NUM_REQ*8-1:0] req_b;
    logic [NUM_REQ*3-1:0] req_op;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [ID_W-1:0]      rsp_id;
    logic [7:0]           rsp_result;
    logic                 rsp_carry;
    logic                 rsp_zero;
    logic                 rsp_illegal;
    logic                 busy;

    typedef struct {
        int id;
        int result;
        int carry;
        int zero;
        int illegal;
    } rsp_t;

    rsp_t exp_q[$];
    rsp_t last_rsp;
    int   checks    = 0;
    int   errors    = 0;
    int   cyc       = 0;
    bit   in_flight = 1'b0;
    int   due       = 0;
    int   model_ptr = 0;
    int   rsp_cnt   = 0;

    always #5 clk = ~clk;

    alu_rr_scheduler #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_op      (req_op),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_id      (rsp_id),
        .rsp_result  (rsp_result),
        .rsp_carry   (rsp_carry),
        .rsp_zero    (rsp_zero),
        .rsp_illegal (rsp_illegal),
        .busy        (busy)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference ALU behaviour computed with plain integer arithmetic.
    function automatic rsp_t ref_op(input int id, input int a, input int b, input int op);
        rsp_t r;
        r.id      = id;
        r.carry   = 0;
        r.illegal = 0;
        case (op)
            0: begin r.result = (a + b) % 256;       r.carry = (a + b > 255) ? 1 : 0; end
            1: begin r.result = (a - b + 256) % 256; r.carry = (a < b) ? 1 : 0;       end
            2: r.result = a & b;
            3: r.result = a | b;
            4: r.result = a ^ b;
            5: r.result = 255 - a;
            default: begin r.result = 0; r.illegal = 1; end
        endcase
        r.zero = (r.result == 0) ? 1 : 0;
        return r;
    endfunction

    function automatic int low_idx(input logic [NUM_REQ-1:0] v);
        for (int k = 0; k < NUM_REQ; k++) begin
            if (v[k]) return k;
        end
        return -1;
    endfunction

    // Monitor: predicts grants and responses, compares whenever the DUT presents them.
    always @(negedge clk) begin : monitor
        logic [NUM_REQ-1:0] exp_rdy;
        int                 win;
        rsp_t               e;
        cyc++;
        if (rst) begin
            chk("rst_req_ready",   int'(req_ready), 0);
            chk("rst_rsp_valid",   int'(rsp_valid), 0);
            chk("rst_busy",        int'(busy), 0);
            chk("rst_rsp_result",  int'(rsp_result), 0);
            chk("rst_rsp_carry",   int'(rsp_carry), 0);
            chk("rst_rsp_zero",    int'(rsp_zero), 1);
            chk("rst_rsp_id",      int'(rsp_id), 0);
            chk("rst_rsp_illegal", int'(rsp_illegal), 0);
            exp_q.delete();
            in_flight = 1'b0;
            model_ptr = 0;
        end else begin
            chk("busy", int'(busy), int'(in_flight));
            exp_rdy = '0;
            win     = -1;
            if (!in_flight && req_valid != '0) begin
                for (int k = 0; k < NUM_REQ; k++) begin
                    if (win < 0 && req_valid[(model_ptr + k) % NUM_REQ]) win = (model_ptr + k) % NUM_REQ;
                end
                exp_rdy[win] = 1'b1;
            end
            chk("req_ready", int'(req_ready), int'(exp_rdy));
            if (win >= 0) begin
                exp_q.push_back(ref_op(win, int'(req_a[8*win +: 8]), int'(req_b[8*win +: 8]),
                                       int'(req_op[3*win +: 3])));
                in_flight = 1'b1;
                due       = cyc + 2;
                model_ptr = (win + 1) % NUM_REQ;
            end
            chk("rsp_valid", int'(rsp_valid), (in_flight && cyc >= due) ? 1 : 0);
            if (rsp_valid && exp_q.size() > 0) begin
                e = exp_q[0];
                chk("rsp_id",      int'(rsp_id), e.id);
                chk("rsp_result",  int'(rsp_result), e.result);
                chk("rsp_carry",   int'(rsp_carry), e.carry);
                chk("rsp_zero",    int'(rsp_zero), e.zero);
                chk("rsp_illegal", int'(rsp_illegal), e.illegal);
                if (rsp_ready) begin
                    void'(exp_q.pop_front());
                    in_flight        = 1'b0;
                    last_rsp.id      = int'(rsp_id);
                    last_rsp.result  = int'(rsp_result);
                    last_rsp.carry   = int'(rsp_carry);
                    last_rsp.zero    = int'(rsp_zero);
                    last_rsp.illegal = int'(rsp_illegal);
                    rsp_cnt++;
                    $display("rsp #%0d id=%0d result=0x%02h carry=%0d zero=%0d illegal=%0d",
                             rsp_cnt, rsp_id, rsp_result, rsp_carry, rsp_zero, rsp_illegal);
                end
            end
        end
    end

    // All stimulus tasks start and end at posedge + #1.
    task automatic set_req(input int i, input int a, input int b, input int op);
        req_valid[i]       = 1'b1;
        req_a[8*i +: 8]    = 8'(a);
        req_b[8*i +: 8]    = 8'(b);
        req_op[3*i +: 3]   = 3'(op);
    endtask

    task automatic issue(input int i, input int a, input int b, input int op);
        int n = 0;
        set_req(i, a, b, op);
        do begin
            @(negedge clk);
            n++;
        end while (!req_ready[i] && n < 50);
        chk("grant_wait", int'(req_ready[i]), 1);
        @(posedge clk);
        #1;
        req_valid[i] = 1'b0;
    endtask

    task automatic wait_rsp(input int target);
        int n = 0;
        while (rsp_cnt < target && n < 50) begin
            @(posedge clk);
            n++;
        end
        chk("rsp_wait", (rsp_cnt >= target) ? 1 : 0, 1);
        if (n == 0) @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < 50);
        chk("idle_wait", int'(busy), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    function automatic int pick_operand();
        case ($urandom_range(0, 5))
            0: return 0;
            1: return 255;
            2: return 1;
            default: return int'($urandom_range(0, 255));
        endcase
    endfunction

    initial begin : stimulus
        int                 base;
        int                 n;
        logic [NUM_REQ-1:0] gnt;
        rst       = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_op    = '0;
        rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Single ADD with carry-out and zero result.
        issue(2, 'hFF, 'h01, 0);
        wait_rsp(1);
        chk("add_id",     last_rsp.id, 2);
        chk("add_result", last_rsp.result, 'h00);
        chk("add_carry",  last_rsp.carry, 1);
        chk("add_zero",   last_rsp.zero, 1);

        // Fairness under full load after reset.
        do_reset();
        base = rsp_cnt;
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 'h00, 'h01, 1);
        for (int g = 0; g < 6; g++) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (req_ready == '0 && n < 20);
            chk("fair_grant", low_idx(req_ready), g % NUM_REQ);
            @(posedge clk);
            #1;
        end
        req_valid = '0;
        wait_rsp(base + 6);
        chk("fair_result", last_rsp.result, 'hFF);
        chk("fair_borrow", last_rsp.carry, 1);
        wait_idle();

        // Backpressure: response held while another requester waits.
        rsp_ready = 1'b0;
        issue(1, 'hAA, 'h55, 4);
        set_req(3, 'h10, 'h20, 0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rsp_valid && n < 20);
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            chk("bp_valid",  int'(rsp_valid), 1);
            chk("bp_result", int'(rsp_result), 'hFF);
            chk("bp_id",     int'(rsp_id), 1);
            chk("bp_ready",  int'(req_ready), 0);
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_accept_ready", int'(req_ready), 0);
        @(negedge clk);
        chk("bp_next_grant", int'(req_ready), 'b1000);
        @(posedge clk);
        #1;
        req_valid[3] = 1'b0;
        wait_idle();

        // Illegal opcode.
        base = rsp_cnt;
        issue(0, 'hAB, 'hCD, 6);
        wait_rsp(base + 1);
        chk("ill_result",  last_rsp.result, 'h00);
        chk("ill_zero",    last_rsp.zero, 1);
        chk("ill_illegal", last_rsp.illegal, 1);
        wait_idle();

        // Reset while a response is pending.
        base      = rsp_cnt;
        rsp_ready = 1'b0;
        issue(2, 'h12, 'h34, 0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rsp_valid && n < 20);
        chk("rr_pre_valid", int'(rsp_valid), 1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("rr_async_valid",  int'(rsp_valid), 0);
        chk("rr_async_busy",   int'(busy), 0);
        chk("rr_async_result", int'(rsp_result), 0);
        chk("rr_async_zero",   int'(rsp_zero), 1);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        rsp_ready = 1'b1;
        set_req(3, 'h01, 'h01, 2);
        set_req(0, 'h0F, 'hF0, 3);
        @(negedge clk);
        chk("rr_first_grant", int'(req_ready), 'b0001);
        @(posedge clk);
        #1;
        req_valid = '0;
        chk("rr_no_rsp", rsp_cnt, base);
        wait_idle();
        chk("rr_one_rsp", rsp_cnt, base + 1);
        chk("rr_rsp_id",  last_rsp.id, 0);

        // Random traffic with random backpressure.
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            gnt = req_valid & req_ready;
            @(posedge clk);
            #1;
            rsp_ready = ($urandom_range(0, 9) < 7);
            for (int i = 0; i < NUM_REQ; i++) begin
                if (gnt[i] || !req_valid[i]) begin
                    if ($urandom_range(0, 2) == 0)
                        set_req(i, pick_operand(), pick_operand(), int'($urandom_range(0, 7)));
                    else
                        req_valid[i] = 1'b0;
                end else if ($urandom_range(0, 19) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
        end

        req_valid = '0;
        rsp_ready = 1'b1;
        wait_idle();
        chk("queue_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_rr_scheduler.md
# alu_rr_scheduler

Round-robin scheduler that shares one `alu_8bit` instance among `NUM_REQ` independent requesters. Each requester issues an (a, b, opcode) command over a valid/ready handshake. The scheduler grants one command at a time, sequences it through the ALU's registered datapath, and returns the result, carry, zero flag and requester ID over a single response channel with backpressure. It sits between the command sources and the ALU and is the only block that drives ALU operands.

## Interface

Parameters:
- `NUM_REQ`, default 4: number of requesters (2..8).
- `ID_W`, default 2: width of requester ID, equal to `$clog2(NUM_REQ)`.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `req_valid`  in  NUM_REQ  per-requester command valid.
- `req_ready`  out  NUM_REQ  per-requester accept; at most one bit set.
- `req_a`  in  NUM_REQ*8  operand A; requester i occupies [8i+7:8i].
- `req_b`  in  NUM_REQ*8  operand B, same packing.
- `req_op`  in  NUM_REQ*3  opcode; requester i occupies [3i+2:3i].
- `rsp_valid`  out  1  response valid.
- `rsp_ready`  in  1  response consumer accept.
- `rsp_id`  out  ID_W  requester index of the response.
- `rsp_result`  out  8  ALU result.
- `rsp_carry`  out  1  ALU carry (ADD) or borrow (SUB); 0 for all other opcodes.
- `rsp_zero`  out  1  ALU zero flag.
- `rsp_illegal`  out  1  opcode was 110 or 111 (result 0x00).
- `busy`  out  1  high in EXEC and RESP.

## Operation

- Opcodes: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 NOT A. Opcodes 110 and 111 give result 0x00 and carry 0.
  - ADD: 9-bit sum, carry = bit 8.
  - SUB: 9-bit a−b, borrow = bit 8.
  - Zero flag = (result == 0).
- FSM states:
  - IDLE to EXEC on any `req_valid`.
  - EXEC to RESP unconditionally.
  - RESP to IDLE when `rsp_ready` is high.
- IDLE:
  - Arbiter picks the first valid requester, searching `ptr`, `ptr+1`, … with modulo-NUM_REQ wrap.
  - `req_ready[winner]` is asserted combinationally in the same cycle.
  - On that edge, capture a, b, op and the winner ID into operand registers, and set `ptr <= winner+1` with wrap.
- EXEC: operand registers drive the ALU. The ALU latches its output at the end of this cycle.
- RESP:
  - `rsp_valid` = 1. `rsp_result`, `rsp_carry` and `rsp_zero` pass through directly from the ALU outputs.
  - Operand registers are held, so the ALU output stays stable for the whole hold.
  - `rsp_id` and `rsp_illegal` come from the captured registers.
- `req_ready` is 0 outside IDLE. Requests arriving in EXEC or RESP wait.
- A requester that drops `req_valid` before grant is simply skipped. No bookkeeping is kept.
- The ALU's `rst_n` is driven with `~rst`.

## Timing

- Reset values:
  - State IDLE, `ptr` = 0, `req_ready` = 0 while `rst` is high.
  - `rsp_valid`, `busy`, `rsp_illegal` = 0.
  - `rsp_id` = 0.
  - `rsp_result` = 0x00, `rsp_carry` = 0, `rsp_zero` = 1 (ALU reset values).
- Latency: accept edge (cycle 0), then `rsp_valid` rises at cycle 2.
  - Minimum issue interval is 3 cycles per command when `rsp_ready` is tied high.
- With `rsp_ready` low, RESP holds indefinitely. All `rsp_*` outputs must be stable until the accepting edge.
- Simultaneous requests: exactly one grant per IDLE cycle, chosen by the pointer order.
  - Under full load with all bits of `req_valid` held high, grants are 0,1,2,3,0,…
- Wrap: after granting requester NUM_REQ−1, `ptr` returns to 0.
- Reset mid-operation, in EXEC or RESP:
  - The transaction is dropped with no response.
  - All outputs take their reset values asynchronously.
  - The first grant after release searches from requester 0.

## Structure

- Shared package `alu_pkg`:
  - opcode localparams `OP_ADD`..`OP_NOT`;
  - `alu_sched_state_t` enum (IDLE, EXEC, RESP);
  - function `is_illegal_op`.
- One sub-module, `rr_arbiter`: parameterised NUM_REQ, combinational, inputs `req` and `ptr`, outputs a one-hot `grant` and the grant index.
- The FSM, operand registers and `alu_8bit` instance live in `alu_rr_scheduler`, about 200 RTL lines.

## Test plan

- Reset: `rst` = 1 for 2 cycles → `rsp_valid` = 0, `req_ready` = 0, `rsp_result` = 0x00, `rsp_zero` = 1.
- Single ADD: req 2, a = 0xFF, b = 0x01, op = 000, `rsp_ready` = 1 → `rsp_valid` 2 cycles after accept, `rsp_id` = 2, result 0x00, carry 1, zero 1.
- Fairness: all 4 requesters valid continuously, each doing SUB with a = 0x00, b = 0x01 → grant order 0,1,2,3,0,1, each response is result 0xFF with borrow 1.
- Backpressure: XOR 0xAA^0x55 with `rsp_ready` held low 5 cycles → outputs hold 0xFF and id stable, no new `req_ready`; the next grant follows the rsp accept edge.
- Illegal op: op = 110, a = 0xAB, b = 0xCD → result 0x00, zero 1, `rsp_illegal` 1.
- Reset in RESP: pulse `rst` while `rsp_valid` = 1 → `rsp_valid` drops immediately with no response; after release, requesters 3 and 0 both valid → requester 0 granted first.
